jk_ubus_arbiter: RTL and testbench

//   Central UBUS bus controller: arbitrates NUM_MASTERS requesters round-robin and tracks each

---
 rtl/jk_ubus_arb_pkg.sv | 18 +
 rtl/jk_ubus_arbiter_if.sv | 33 +++
 rtl/jk_ubus_rr_picker.sv | 51 +++++
 rtl/jk_ubus_arbiter.sv | 125 ++++++++++++
 tb/tb_jk_ubus_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_ubus_arb_pkg.sv
// Shared types and helpers for the UBUS arbiter: FSM state encoding and
// burst-size decoding used by the transfer tracker.
package jk_ubus_arb_pkg;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB,
    ADDR,
    DATA
  } arb_state_e;

  // size encodes log2 of the beat count, so 3 gives an 8-beat burst
  function automatic logic [BEAT_CNT_W-1:0] size_to_beats(input logic [1:0] size);
    return BEAT_CNT_W'(1) << size;
  endfunction

endpackage

// File: rtl/jk_ubus_arbiter_if.sv
// UBUS control-plane bundle between the bus controller and the requesters/slave side.
// The master modport is the controller's view and the slave modport is the bus agents' view.
interface jk_ubus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);

  localparam int ID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   read;
  logic                   write;
  logic [1:0]             size;
  logic                   bip;
  logic                   wait_state;
  logic                   error;
  logic                   addr_phase;
  logic                   data_phase;
  logic [ID_W-1:0]        owner_id;
  logic                   timeout;
  logic                   protocol_err;

  modport master (
    input  req, read, write, size, bip, wait_state, error,
    output gnt, addr_phase, data_phase, owner_id, timeout, protocol_err
  );

  modport slave (
    output req, read, write, size, bip, wait_state, error,
    input  gnt, addr_phase, data_phase, owner_id, timeout, protocol_err
  );

endinterface

// File: rtl/jk_ubus_rr_picker.sv
// Combinational round-robin selector: picks the first asserted request at or
// after ptr (wrapping) and reports the pointer value that follows the winner.
module jk_ubus_rr_picker #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic                           valid,
  output logic [$clog2(NUM_MASTERS)-1:0] sel,
  output logic [$clog2(NUM_MASTERS)-1:0] next_ptr
);

  localparam int              ID_W = $clog2(NUM_MASTERS);
  localparam logic [ID_W:0]   N_W  = (ID_W + 1)'(NUM_MASTERS);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [NUM_MASTERS-1:0]   first_oh;
  logic [ID_W-1:0]          idx_terms [NUM_MASTERS];
  logic [ID_W-1:0]          offset;
  logic [ID_W:0]            sum;
  logic [ID_W:0]            nxt;

  // Rotating a doubled copy puts the ptr-th request at bit 0
  assign req_dbl  = {req, req};
  assign req_rot  = NUM_MASTERS'(req_dbl >> ptr);
  assign first_oh = req_rot & (~req_rot + NUM_MASTERS'(1));

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_idx
      assign idx_terms[gi] = first_oh[gi] ? ID_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      offset = offset | idx_terms[i];
    end
  end

  // Undo the rotation modulo NUM_MASTERS, which need not be a power of two
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    sel = (sum >= N_W) ? ID_W'(sum - N_W) : sum[ID_W-1:0];
    nxt = {1'b0, sel} + (ID_W + 1)'(1);
    next_ptr = (nxt >= N_W) ? '0 : nxt[ID_W-1:0];
    valid = |req;
  end

endmodule

// File: rtl/jk_ubus_arbiter.sv
// Central UBUS controller: round-robin grant, address/data phase tracking,
// bip/size framing checks and a per-beat wait-state watchdog.
module jk_ubus_arbiter
  import jk_ubus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  jk_ubus_arbiter_if.master bus
);

  localparam int                ID_W      = $clog2(NUM_MASTERS);
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_reg;
  logic [ID_W-1:0]        ptr_reg;
  logic [BEAT_CNT_W-1:0]  beat_cnt_reg;
  logic [WAIT_W-1:0]      wait_cnt_reg;
  logic [NUM_MASTERS-1:0] gnt_reg;
  logic                   addr_phase_reg;
  logic                   data_phase_reg;
  logic [ID_W-1:0]        owner_id_reg;
  logic                   timeout_reg;
  logic                   protocol_err_reg;

  logic                   pick_valid;
  logic [ID_W-1:0]        pick_sel;
  logic [ID_W-1:0]        pick_next_ptr;

  jk_ubus_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req      (bus.req),
    .ptr      (ptr_reg),
    .valid    (pick_valid),
    .sel      (pick_sel),
    .next_ptr (pick_next_ptr)
  );

  assign bus.gnt          = gnt_reg;
  assign bus.addr_phase   = addr_phase_reg;
  assign bus.data_phase   = data_phase_reg;
  assign bus.owner_id     = owner_id_reg;
  assign bus.timeout      = timeout_reg;
  assign bus.protocol_err = protocol_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ARB;
      ptr_reg          <= '0;
      beat_cnt_reg     <= '0;
      wait_cnt_reg     <= '0;
      gnt_reg          <= '0;
      addr_phase_reg   <= 1'b0;
      data_phase_reg   <= 1'b0;
      owner_id_reg     <= '0;
      timeout_reg      <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      gnt_reg          <= '0;
      timeout_reg      <= 1'b0;
      protocol_err_reg <= 1'b0;
      case (state_reg)
        ARB: begin
          if (pick_valid) begin
            gnt_reg      <= NUM_MASTERS'(1) << pick_sel;
            owner_id_reg <= pick_sel;
            ptr_reg      <= pick_next_ptr;
            state_reg    <= ADDR;
          end
        end
        ADDR: begin
          // First ADDR cycle carries the grant pulse; the second is the address phase
          if (!addr_phase_reg) begin
            addr_phase_reg <= 1'b1;
          end else begin
            addr_phase_reg <= 1'b0;
            if (bus.read && bus.write) begin
              protocol_err_reg <= 1'b1;
              state_reg        <= ARB;
            end else if (!bus.read && !bus.write) begin
              state_reg <= ARB;
            end else begin
              beat_cnt_reg   <= size_to_beats(bus.size);
              wait_cnt_reg   <= '0;
              data_phase_reg <= 1'b1;
              state_reg      <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.wait_state) begin
            if (wait_cnt_reg == WAIT_LAST) begin
              timeout_reg    <= 1'b1;
              wait_cnt_reg   <= '0;
              data_phase_reg <= 1'b0;
              state_reg      <= ARB;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
          end else begin
            wait_cnt_reg <= '0;
            // A slave error aborts the burst outright, so bip framing is moot on that beat
            if (bus.error) begin
              data_phase_reg <= 1'b0;
              state_reg      <= ARB;
            end else if (beat_cnt_reg > BEAT_CNT_W'(1)) begin
              protocol_err_reg <= !bus.bip;
              beat_cnt_reg     <= beat_cnt_reg - BEAT_CNT_W'(1);
            end else begin
              protocol_err_reg <= bus.bip;
              data_phase_reg   <= 1'b0;
              state_reg        <= ARB;
            end
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ubus_arbiter.sv
// Directed and randomized transfers against a transaction-level model of the
// UBUS arbiter (rr winner, data-cycle count, protocol_err and timeout pulses).
module tb_jk_ubus_arbiter;

  localparam int NM = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic w;
    logic b;
    logic e;
  } stim_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_ptr;
  int   gnt_cyc;

  jk_ubus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  jk_ubus_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after p, wrapping around the ring
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NM; i++) begin
      int idx;
      idx = (p + i) % NM;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return 0;
  endfunction

  // Runs one transfer starting at a negedge in ARB; returns at the negedge of the next ARB cycle.
  task automatic run_xfer(input string nm, input logic [3:0] rq, input logic [3:0] rq_after,
                          input logic rd, input logic wr, input logic [1:0] sz,
                          input int stall_b, input int stall_n, input int badbip_b, input int err_b);
    int    w;
    int    beats;
    int    exp_dc;
    int    exp_pe;
    int    exp_to;
    int    dc;
    int    pe;
    int    to_c;
    int    guard;
    stim_t s;
    stim_t q[$];

    w = rr_pick(rq, exp_ptr);
    bus.req = rq;
    @(negedge clk);
    chk({nm, ":gnt"}, 32'(bus.gnt), 32'(1 << w));
    chk({nm, ":owner"}, 32'(bus.owner_id), 32'(w));
    gnt_cyc = cyc;
    exp_ptr = (w + 1) % NM;
    bus.req = rq_after;

    @(negedge clk);
    chk({nm, ":addr_phase"}, 32'(bus.addr_phase), 32'd1);
    chk({nm, ":gnt_pulse"}, 32'(bus.gnt), 32'd0);
    bus.read  = rd;
    bus.write = wr;
    bus.size  = sz;

    exp_dc = 0;
    exp_pe = 0;
    exp_to = 0;
    if (rd && wr) begin
      exp_pe = 1;
    end else if (rd || wr) begin
      beats = 1 << sz;
      for (int b = 0; b < beats; b++) begin
        int   ns;
        logic last;
        logic bv;
        ns   = (b == stall_b) ? stall_n : 0;
        last = (b == beats - 1);
        bv   = (b == badbip_b) ? last : !last;
        for (int k = 0; k < ns; k++) q.push_back(stim_t'{1'b1, !last, 1'b0});
        if (ns >= TO) begin
          exp_dc += TO;
          exp_to  = 1;
          break;
        end
        exp_dc += ns + 1;
        q.push_back(stim_t'{1'b0, bv, (b == err_b)});
        if (b == err_b) break;
        if (bv == last) exp_pe++;
        if (last) break;
      end
    end

    dc    = 0;
    pe    = 0;
    to_c  = 0;
    guard = 0;
    while (guard < 300) begin
      @(negedge clk);
      guard++;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      pe   += int'(bus.protocol_err);
      to_c += int'(bus.timeout);
      if (!bus.data_phase) break;
      dc++;
      if (q.size() > 0) s = q.pop_front();
      else s = '0;
      bus.wait_state = s.w;
      bus.bip        = s.b;
      bus.error      = s.e;
    end
    bus.wait_state = 1'b0;
    bus.bip        = 1'b0;
    bus.error      = 1'b0;

    chk({nm, ":ended"}, 32'(guard < 300), 32'd1);
    chk({nm, ":data_cycles"}, 32'(dc), 32'(exp_dc));
    chk({nm, ":protocol_err"}, 32'(pe), 32'(exp_pe));
    chk({nm, ":timeout"}, 32'(to_c), 32'(exp_to));
    chk({nm, ":owner_hold"}, 32'(bus.owner_id), 32'(w));
    chk({nm, ":idle"}, 32'({bus.gnt, bus.addr_phase}), 32'd0);
    $display("xfer %s req=%b winner=%0d rd=%0d wr=%0d size=%0d dcyc=%0d perr=%0d tmo=%0d",
             nm, rq, w, rd, wr, sz, dc, pe, to_c);
  endtask

  initial begin
    int prev;
    checks         = 0;
    errors         = 0;
    exp_ptr        = 0;
    gnt_cyc        = 0;
    reset          = 1'b0;
    bus.req        = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.size       = '0;
    bus.bip        = 1'b0;
    bus.wait_state = 1'b0;
    bus.error      = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst:gnt", 32'(bus.gnt), 32'd0);
    chk("rst:phases", 32'({bus.addr_phase, bus.data_phase}), 32'd0);
    chk("rst:owner", 32'(bus.owner_id), 32'd0);
    chk("rst:pulses", 32'({bus.timeout, bus.protocol_err}), 32'd0);
    reset = 1'b1;

    // Four masters contending with NOP transfers: strict rotation, 3-cycle grant spacing
    for (int k = 0; k < 5; k++) begin
      prev = gnt_cyc;
      run_xfer("t2_nop", 4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, -1, 0, -1, -1);
      if (k > 0) chk("t2:gap", 32'(gnt_cyc - prev), 32'd3);
    end

    run_xfer("t3_write4", 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd2, -1, 0, -1, -1);
    run_xfer("t4_stall", 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1, 0, 16, -1, -1);
    run_xfer("t4_after", 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, -1, 0, -1, -1);
    run_xfer("t5_badbip", 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd2, -1, 0, 1, -1);
    run_xfer("t5_rdwr", 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, -1, 0, -1, -1);
    run_xfer("t6_slverr", 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd3, -1, 0, -1, 1);

    // Reset in the middle of an 8-beat burst after three beats have completed
    bus.req = 4'b0100;
    @(negedge clk);
    chk("t1:gnt", 32'(bus.gnt), 32'(1 << rr_pick(4'b0100, exp_ptr)));
    bus.req = '0;
    @(negedge clk);
    bus.write = 1'b1;
    bus.size  = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.write      = 1'b0;
      bus.bip        = 1'b1;
      bus.wait_state = 1'b0;
      chk("t1:in_data", 32'(bus.data_phase), 32'd1);
    end
    @(negedge clk);
    chk("t1:mid_data", 32'(bus.data_phase), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1:gnt", 32'(bus.gnt), 32'd0);
    chk("t1:phases", 32'({bus.addr_phase, bus.data_phase}), 32'd0);
    chk("t1:owner", 32'(bus.owner_id), 32'd0);
    chk("t1:pulses", 32'({bus.timeout, bus.protocol_err}), 32'd0);
    exp_ptr = 0;
    @(negedge clk);
    reset   = 1'b1;
    bus.bip = 1'b0;
    run_xfer("t1_after", 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, -1, 0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rq;
      logic [3:0] rqa;
      logic       rd;
      logic       wr;
      int         op;
      int         sb;
      int         sn;
      int         bb;
      int         eb;
      rq  = 4'($urandom_range(1, 15));
      rqa = 4'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 9));
      rd  = 1'b0;
      wr  = 1'b0;
      if (op == 1) begin
        rd = 1'b1;
        wr = 1'b1;
      end else if (op > 1) begin
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end
      sb = int'($urandom_range(0, 7));
      sn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 3));
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_xfer("rand", rq, rqa, rd, wr, 2'($urandom_range(0, 3)), sb, sn, bb, eb);
    end
    bus.req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
